vector_element_aligner: RTL and testbench
=========================================

Name: vector_element_aligner

Overview:
- Parametrised sequential successor to the VPU lane-select/zero-extend logic on the ALU1 address path.
- Accepts a stream of DATA_W-bit memory/register words, starting at any byte offset.
- Emits a counted sequence of SEW-sized elements, one per cycle, zero- or sign-extended to DATA_W.
- Elements that straddle a word boundary are reassembled from a two-word byte buffer; valid/ready handshakes on both sides.

Parameters:
DATA_W, 32, word and output element width in bits; legal values 32 or 64.
CNT_W, 8, width of element-count field; max count 2^CNT_W-1.

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_start  input  1  one-cycle request to begin; sampled only in IDLE.
i_width  input  3  element width: 000 byte, 001 half, 010 word, 011 dword (legal only when DATA_W=64); 1xx illegal.
i_sign  input  1  1 = sign-extend, 0 = zero-extend.
i_offset  input  log2(DATA_W/8)  starting byte offset inside the first word.
i_count  input  CNT_W  number of elements to emit.
i_word_valid  input  1  input word valid.
i_word  input  DATA_W  input word, little-endian byte order.
o_word_ready  output  1  input word accepted when valid and ready are both high.
o_elem_valid  output  1  output element valid.
o_elem  output  DATA_W  extended element.
i_elem_ready  input  1  consumer accepts the element.
o_busy  output  1  high in RUN.
o_done  output  1  one-cycle pulse after the last element handshake.
o_err  output  1  one-cycle pulse when a start has an illegal width.

Behaviour:
- Reset (async, i_rst_n low): state IDLE; buffer fill 0; all outputs 0 (o_elem = 0).
- Start latch: i_width, i_sign, i_offset and i_count are latched on accepted i_start. Later changes to these inputs are ignored until the next start.
- States:
  - IDLE: on i_start with an illegal width (1xx, or 011 with DATA_W=32), pulse o_err next cycle and stay IDLE. On i_start with count 0, go to DONE without consuming words. Otherwise go to RUN.
  - RUN: o_busy=1. Go to DONE on the handshake of element i_count.
  - DONE: o_done=1 for exactly one cycle, then IDLE.
- i_start in RUN or DONE is ignored.
- Buffer: 2*DATA_W bits, byte fill counter. Element size SZ = 1/2/4/8 bytes.
- First accepted word is shifted right by i_offset bytes; fill = DATA_W/8 - offset. Later words are appended at byte position fill.
- o_word_ready = RUN && fill <= DATA_W/8 && (bytes still needed > fill), where bytes still needed = remaining elements × SZ.
- Extraction: when fill >= SZ and the output register is empty or being consumed this cycle, the low SZ bytes are extended and loaded into o_elem. The buffer shifts down SZ bytes and fill decreases by SZ.
- Extraction and word acceptance in the same cycle are legal: new fill = fill - SZ + DATA_W/8, with the word placed at byte position fill - SZ.
- Throughput: one element per cycle when unstalled. First o_elem_valid appears one cycle after the first word handshake, if that word supplies >= SZ bytes.
- Output holding: o_elem_valid stays high and o_elem stays stable until i_elem_ready.
- Termination: after the last element, surplus buffered bytes are discarded and fill clears. No further words are requested.
- Reset mid-RUN: immediate return to IDLE with all state cleared. The partial transfer is lost, with no o_done.

Test Plan:
- DATA_W=32, byte, offset 0, count 4, zero-ext, word 0x84C3B2A1 -> elements 0xA1, 0xB2, 0xC3, 0x84 on four consecutive cycles; o_done pulse; one word consumed.
- Same with i_sign=1 -> 4th element 0xFFFFFF84; 1st element 0xFFFFFFA1.
- Half, offset 3, count 2, words 0x44332211 then 0x88776655 -> 0x00005544, 0x00007766; exactly two words consumed; o_word_ready low afterwards.
- Half, count 4, i_elem_ready held low 3 cycles mid-stream -> o_elem stable and valid throughout the stall; no element lost or duplicated; words stall while fill > 4.
- Count 0 -> o_done pulse, no word handshake. Width 011 with DATA_W=32 -> o_err pulse; state stays IDLE, o_busy 0.
- Assert i_rst_n low after 2 of 4 byte elements -> outputs 0 immediately. A new start afterwards with word 0x04030201 -> 0x01..0x04.

Source files
------------

// File: rtl/vector_element_aligner.sv
// Streams DATA_W-bit words in at any byte offset and emits a counted run of
// SEW-sized elements, zero/sign-extended to DATA_W, through a two-word byte buffer.

module vea_lane (
  input  logic [7:0] byte_in,
  input  logic       keep,
  input  logic       fill_bit,
  output logic [7:0] byte_out
);
  assign byte_out = keep ? byte_in : {8{fill_bit}};
endmodule

module vector_element_aligner #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic [2:0]                  i_width,
  input  logic                        i_sign,
  input  logic [$clog2(DATA_W/8)-1:0] i_offset,
  input  logic [CNT_W-1:0]            i_count,
  input  logic                        i_word_valid,
  input  logic [DATA_W-1:0]           i_word,
  output logic                        o_word_ready,
  output logic                        o_elem_valid,
  output logic [DATA_W-1:0]           o_elem,
  input  logic                        i_elem_ready,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_err
);
  localparam int BYTES  = DATA_W / 8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int FILL_W = $clog2(2 * BYTES) + 1;
  localparam int NEED_W = CNT_W + 4;
  localparam int IDX_W  = $clog2(2 * DATA_W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [1:0]          wsel;
  logic                sgn;
  logic [OFF_W-1:0]    off;
  logic [CNT_W-1:0]    rem_ext, rem_out;
  logic                first;
  logic [2*DATA_W-1:0] bq, bq_n;
  logic [FILL_W-1:0]   fill, fill_n;
  logic [DATA_W-1:0]   wsh;
  logic [3:0]          sz;
  logic [NEED_W-1:0]   need;
  logic [IDX_W-1:0]    top_idx;
  logic                sbit, ext, whs, ehs, word_rdy;
  logic [BYTES-1:0][7:0] elem_n;

  assign sz       = 4'd1 << wsel;
  assign need     = NEED_W'(rem_ext) * NEED_W'(sz);
  assign word_rdy = (state == RUN) && (fill <= FILL_W'(BYTES)) && (need > NEED_W'(fill));
  assign o_word_ready = word_rdy;
  assign whs      = i_word_valid && word_rdy;
  assign ehs      = o_elem_valid && i_elem_ready;
  // Output register may be refilled in the same cycle it is consumed.
  assign ext      = (state == RUN) && (rem_ext != '0) && (fill >= FILL_W'(sz)) &&
                    (!o_elem_valid || i_elem_ready);
  assign top_idx  = IDX_W'({sz, 3'b000}) - IDX_W'(1);
  assign sbit     = sgn & bq[top_idx];

  for (genvar g = 0; g < BYTES; g++) begin : g_lane
    vea_lane u_lane (
      .byte_in (bq[g*8 +: 8]),
      .keep    (4'(g) < sz),
      .fill_bit(sbit),
      .byte_out(elem_n[g])
    );
  end

  always_comb begin
    bq_n   = bq;
    fill_n = fill;
    wsh    = '0;
    if (ext) begin
      bq_n   = bq >> {sz, 3'b000};
      fill_n = fill - FILL_W'(sz);
    end
    // Incoming word lands just above whatever survives this cycle's extraction.
    if (whs) begin
      wsh    = first ? (i_word >> {off, 3'b000}) : i_word;
      bq_n   = bq_n | ({{DATA_W{1'b0}}, wsh} << {fill_n, 3'b000});
      fill_n = fill_n + (first ? FILL_W'(BYTES) - FILL_W'(off) : FILL_W'(BYTES));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      wsel         <= '0;
      sgn          <= 1'b0;
      off          <= '0;
      rem_ext      <= '0;
      rem_out      <= '0;
      first        <= 1'b0;
      bq           <= '0;
      fill         <= '0;
      o_elem_valid <= 1'b0;
      o_elem       <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          if (i_width[2] || (i_width[1:0] == 2'b11 && DATA_W != 64)) begin
            o_err <= 1'b1;
          end else begin
            wsel    <= i_width[1:0];
            sgn     <= i_sign;
            off     <= i_offset;
            rem_ext <= i_count;
            rem_out <= i_count;
            first   <= 1'b1;
            bq      <= '0;
            fill    <= '0;
            if (i_count == '0) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              state  <= RUN;
              o_busy <= 1'b1;
            end
          end
        end
        RUN: begin
          bq   <= bq_n;
          fill <= fill_n;
          if (whs) first <= 1'b0;
          if (ext) begin
            rem_ext      <= rem_ext - 1'b1;
            o_elem       <= elem_n;
            o_elem_valid <= 1'b1;
          end else if (ehs) begin
            o_elem_valid <= 1'b0;
          end
          if (ehs) begin
            rem_out <= rem_out - 1'b1;
            // Last element taken: drop surplus bytes, stop requesting words.
            if (rem_out == CNT_W'(1)) begin
              state        <= DONE;
              o_done       <= 1'b1;
              o_busy       <= 1'b0;
              o_elem_valid <= 1'b0;
              bq           <= '0;
              fill         <= '0;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_element_aligner.sv
// Randomized and directed bench for vector_element_aligner against a byte-stream model.
module tb_vector_element_aligner;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int BY = DW / 8;

  logic          i_clk, i_rst_n, i_start, i_sign, i_word_valid, i_elem_ready;
  logic [2:0]    i_width;
  logic [1:0]    i_offset;
  logic [CW-1:0] i_count;
  logic [DW-1:0] i_word, o_elem;
  logic          o_word_ready, o_elem_valid, o_busy, o_done, o_err;

  vector_element_aligner #(.DATA_W(DW), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_width(i_width),
    .i_sign(i_sign), .i_offset(i_offset), .i_count(i_count),
    .i_word_valid(i_word_valid), .i_word(i_word), .o_word_ready(o_word_ready),
    .o_elem_valid(o_elem_valid), .o_elem(o_elem), .i_elem_ready(i_elem_ready),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  int tests = 0, fails = 0;
  logic [DW-1:0] words [64];
  logic [DW-1:0] got   [64];
  int got_cyc [64];
  int nw = 0, ne = 0, cyc = 0;
  int cur_sz = 1, cur_off = 0, cur_cnt = 0;
  bit cur_sgn = 0;
  int word_prob = 100, rdy_prob = 100;
  bit prev_stall = 0;
  logic [DW-1:0] prev_elem = '0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Element idx is bytes [off+idx*sz, off+idx*sz+sz) of the little-endian word stream.
  function automatic logic [DW-1:0] model_elem(int sz, bit sgn, int off, int idx);
    logic [DW-1:0] r;
    logic [DW-1:0] w;
    r = '0;
    for (int k = 0; k < sz; k++) begin
      int p;
      p = off + idx * sz + k;
      w = words[p / BY];
      r[k*8 +: 8] = w[(p % BY)*8 +: 8];
    end
    if (sgn && r[sz*8-1])
      for (int k = sz; k < BY; k++) r[k*8 +: 8] = 8'hFF;
    return r;
  endfunction

  always @(posedge i_clk) begin
    #1;
    i_word_valid = ($urandom_range(99) < word_prob);
    i_word       = words[nw % 64];
    i_elem_ready = ($urandom_range(99) < rdy_prob);
  end

  always @(negedge i_clk) begin
    cyc++;
    if (i_rst_n) begin
      if (prev_stall) begin
        chk("hold_valid", 64'(o_elem_valid), 64'd1);
        chk("hold_elem", 64'(o_elem), 64'(prev_elem));
      end
      if (o_word_ready) chk("ready_only_busy", 64'(o_busy), 64'd1);
      if (i_word_valid && o_word_ready) nw++;
      if (o_elem_valid && i_elem_ready) begin
        if (ne < cur_cnt) begin
          chk($sformatf("elem%0d", ne), 64'(o_elem), 64'(model_elem(cur_sz, cur_sgn, cur_off, ne)));
        end else begin
          tests++;
          fails++;
          $display("FAIL extra_elem: got element %0d expected only %0d", ne + 1, cur_cnt);
        end
        got[ne % 64]     = o_elem;
        got_cyc[ne % 64] = cyc;
        ne++;
      end
      prev_stall = o_elem_valid && !i_elem_ready;
      prev_elem  = o_elem;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic do_start(input int w, input bit s, input int off, input int cnt);
    @(posedge i_clk); #1;
    i_start = 1'b1; i_width = 3'(w); i_sign = s; i_offset = 2'(off); i_count = CW'(cnt);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_width = 3'($urandom); i_sign = 1'($urandom); i_offset = 2'($urandom); i_count = CW'($urandom);
  endtask

  task automatic pulse_reset();
    @(posedge i_clk); #2;
    i_rst_n = 1'b0;
    @(posedge i_clk); #2;
    i_rst_n = 1'b1;
  endtask

  task automatic run_xfer(input int w, input bit s, input int off, input int cnt,
                          input int wp, input int rp);
    int t, exp_words;
    cur_sz = 1 << w; cur_sgn = s; cur_off = off; cur_cnt = cnt;
    ne = 0; nw = 0; word_prob = wp; rdy_prob = rp;
    exp_words = (cnt == 0) ? 0 : (off + cnt * cur_sz + BY - 1) / BY;
    do_start(w, s, off, cnt);
    for (t = 0; t < 3000; t++) begin
      @(negedge i_clk);
      if (t == 0 && cnt != 0) chk("busy_run", 64'(o_busy), 64'd1);
      if (o_done) break;
    end
    if (t >= 3000) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no o_done after %0d cycles, expected a pulse", t);
      pulse_reset();
      return;
    end
    chk("busy_at_done", 64'(o_busy), 64'd0);
    chk("elem_count", 64'(ne), 64'(cnt));
    chk("word_count", 64'(nw), 64'(exp_words));
    @(negedge i_clk);
    chk("done_pulse_width", 64'(o_done), 64'd0);
    chk("idle_no_ready", 64'(o_word_ready), 64'd0);
  endtask

  initial begin
    int t;
    i_rst_n = 1'b0; i_start = 1'b0; i_width = '0; i_sign = 1'b0; i_offset = '0;
    i_count = '0; i_word_valid = 1'b0; i_word = '0; i_elem_ready = 1'b1;
    for (int i = 0; i < 64; i++) words[i] = $urandom;
    repeat (3) @(negedge i_clk);
    chk("rst_valid", 64'(o_elem_valid), 64'd0);
    chk("rst_elem", 64'(o_elem), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    chk("rst_ready", 64'(o_word_ready), 64'd0);
    @(posedge i_clk); #2;
    i_rst_n = 1'b1;

    // Byte, zero-extend, then sign-extend.
    words[0] = 32'h84C3B2A1;
    chk("model_pin_zext", 64'(model_elem(1, 0, 0, 3)), 64'h84);
    chk("model_pin_sext", 64'(model_elem(1, 1, 0, 0)), 64'hFFFFFFA1);
    run_xfer(0, 0, 0, 4, 100, 100);
    chk("b0", 64'(got[0]), 64'hA1);
    chk("b1", 64'(got[1]), 64'hB2);
    chk("b2", 64'(got[2]), 64'hC3);
    chk("b3", 64'(got[3]), 64'h84);
    chk("b_consecutive", 64'(got_cyc[3] - got_cyc[0]), 64'd3);
    run_xfer(0, 1, 0, 4, 100, 100);
    chk("s0", 64'(got[0]), 64'hFFFFFFA1);
    chk("s3", 64'(got[3]), 64'hFFFFFF84);

    // Half, offset 3, straddling two words.
    words[0] = 32'h44332211; words[1] = 32'h88776655;
    run_xfer(1, 0, 3, 2, 100, 100);
    chk("h0", 64'(got[0]), 64'h5544);
    chk("h1", 64'(got[1]), 64'h7766);

    // Half, count 4 with a 3-cycle consumer stall mid-stream.
    for (int i = 0; i < 64; i++) words[i] = $urandom;
    fork
      run_xfer(1, 1, 1, 4, 100, 100);
      begin
        for (int k = 0; k < 200 && ne < 2; k++) @(posedge i_clk);
        rdy_prob = 0;
        repeat (3) @(posedge i_clk);
        rdy_prob = 100;
      end
    join

    // Count 0 and illegal widths.
    run_xfer(2, 0, 2, 0, 100, 100);
    chk("cnt0_no_elem", 64'(ne), 64'd0);
    do_start(3, 0, 0, 4);
    @(negedge i_clk);
    chk("err_w3", 64'(o_err), 64'd1);
    chk("err_busy", 64'(o_busy), 64'd0);
    @(negedge i_clk);
    chk("err_pulse", 64'(o_err), 64'd0);
    chk("err_idle_ready", 64'(o_word_ready), 64'd0);
    do_start(5, 0, 0, 4);
    @(negedge i_clk);
    chk("err_w5", 64'(o_err), 64'd1);

    // Reset mid-transfer, then a clean transfer.
    cur_sz = 1; cur_sgn = 0; cur_off = 0; cur_cnt = 4; ne = 0; nw = 0;
    word_prob = 100; rdy_prob = 100;
    do_start(0, 0, 0, 4);
    for (t = 0; t < 200 && ne < 2; t++) @(negedge i_clk);
    chk("mid_reached", 64'(ne >= 2), 64'd1);
    @(posedge i_clk); #2;
    i_rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(o_elem_valid), 64'd0);
    chk("mrst_elem", 64'(o_elem), 64'd0);
    chk("mrst_busy", 64'(o_busy), 64'd0);
    chk("mrst_ready", 64'(o_word_ready), 64'd0);
    @(posedge i_clk); #2;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("mrst_no_done", 64'(o_done), 64'd0);
    words[0] = 32'h04030201;
    run_xfer(0, 0, 0, 4, 100, 100);
    chk("r0", 64'(got[0]), 64'h01);
    chk("r3", 64'(got[3]), 64'h04);

    // Randomized transfers with random back-pressure on both sides.
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 64; i++) words[i] = $urandom;
      run_xfer($urandom_range(2), 1'($urandom), $urandom_range(3), $urandom_range(40),
               $urandom_range(30, 100), $urandom_range(30, 100));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
